mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main sequencing FSM for the multicycle MIPS32 datapath. Decodes the instruction register opcode/funct, steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select, including the 2-bit ALU op consumed by the ALU control block. Sits between the instruction register and the shared single-port memory, ALU and register file; it waits on memory through a ready handshake.

## Interface
- No parameters; opcodes are fixed: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, ori=001101, j=000010; jr is R-type with funct=001000.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational from the current ALU inputs.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC load enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  IR load.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2.
- zero_ext  out  1  1 selects zero-extension of imm (ori).
- alu_op  out  2  00=add, 01=sub, 10=use funct, 11=or.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr).
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, ORI_EXEC, ORI_WB, BRANCH, JUMP, JR. Encoding is free.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_en are asserted only when mem_ready=1. The FSM holds in FETCH while mem_ready=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state is chosen by opcode:
  - lw/sw → MEM_ADDR
  - R → JR if funct=001000, else R_EXEC
  - ori → ORI_EXEC
  - beq/bne → BRANCH
  - j → JUMP
  - any other opcode → FETCH, with illegal=1 and instr_done=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, iord=1; holds until mem_ready; instr_done=1 in the mem_ready cycle → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1 → FETCH.
- ORI_EXEC: alu_src_a=1, alu_src_b=10, zero_ext=1, alu_op=11 → ORI_WB.
- ORI_WB: reg_write=1, reg_dst=0, instr_done=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1. pc_en = zero for beq and ~zero for bne → FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1 → FETCH.
- JR: pc_source=11, pc_en=1, instr_done=1 → FETCH.

## Timing
- Outputs are Moore decodes of state, with three exceptions:
  - ir_write and FETCH pc_en are gated by mem_ready.
  - BRANCH pc_en is gated by zero.
  - DECODE illegal is decoded from opcode.
- Reset: the state goes to FETCH immediately and asynchronously. The reset output values are the FETCH values with mem_ready treated as 0: mem_read=1, alu_src_b=01, everything else 0.
- Asserting reset mid-instruction aborts it. No reg_write, mem_write or pc_en occurs while rst_n=0.
- Zero-wait latencies from FETCH entry to instr_done, inclusive:
  - lw: 5 cycles
  - sw, R-type, ori: 4 cycles
  - beq, bne, j, jr: 3 cycles
  - illegal: 2 cycles
- Each memory wait cycle adds 1 cycle. During a wait, all outputs stay stable and no write strobe toggles.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.

## Test plan
- Reset then mem_ready=1 with an add (opcode 000000, funct 100000):
  - States: FETCH, DECODE, R_EXEC, R_WB.
  - alu_op=10 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB.
  - instr_done on cycle 4.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD:
  - ir_write pulses exactly once.
  - mem_read stays high throughout.
  - instr_done on cycle 10; mem_to_reg=1 on the writeback cycle.
- beq with zero=1, then beq with zero=0, then bne with zero=0:
  - pc_en in BRANCH is 1, then 0, then 1.
  - pc_source=01 and alu_op=01 each time.
- ori (001101) → zero_ext=1 and alu_op=11 in ORI_EXEC; jr (R-type, funct 001000) → pc_source=11 and pc_en=1 in the third cycle.
- Illegal opcode 111111 → illegal=1 and instr_done=1 in DECODE, with no reg_write or pc_en, and the FSM returns to FETCH.
- rst_n pulled low during MEM_WR while mem_ready=0 → mem_write drops to 0 in the same cycle, the outputs show FETCH values, and no write occurs after release.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS sequencer and its datapath.
// The sequencer is the master; the datapath/memory side is the slave.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, zero_ext, alu_op, pc_source,
               instr_done, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, zero_ext, alu_op, pc_source,
               instr_done, illegal
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main sequencing FSM of the multicycle MIPS32 datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
module mips_multicycle_control (
    input  logic                           clk,
    input  logic                           rst_n,
    mips_multicycle_control_if.master      bus
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_ORI_EXEC = 4'd8,
        S_ORI_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    // Registered Moore controls plus state flags used by the input-gated outputs.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_en_u;
        logic       done_u;
        logic       in_fetch;
        logic       in_decode;
        logic       in_branch;
        logic       in_memwr;
    } ctrl_t;

    state_t state_r;
    state_t state_nxt_s;
    ctrl_t  ctrl_r;
    logic   mem_ready_s;
    logic   fetch_go_s;
    logic   branch_take_s;
    logic   illegal_s;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ORI, OP_J: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t ctrl_decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.in_fetch  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.in_decode = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done_u     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.in_memwr  = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done_u    = 1'b1;
            end
            S_ORI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.zero_ext  = 1'b1;
                c.alu_op    = 2'b11;
            end
            S_ORI_WB: begin
                c.reg_write = 1'b1;
                c.done_u    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
                c.done_u    = 1'b1;
                c.in_branch = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_en_u   = 1'b1;
                c.done_u    = 1'b1;
            end
            S_JR: begin
                c.pc_source = 2'b11;
                c.pc_en_u   = 1'b1;
                c.done_u    = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state selection; memory states hold until mem_ready.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (bus.mem_ready) state_nxt_s = S_DECODE;
                else               state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   state_nxt_s = S_MEM_ADDR;
                    OP_R: begin
                        if (bus.funct == FN_JR) state_nxt_s = S_JR;
                        else                    state_nxt_s = S_R_EXEC;
                    end
                    OP_ORI:         state_nxt_s = S_ORI_EXEC;
                    OP_BEQ, OP_BNE: state_nxt_s = S_BRANCH;
                    OP_J:           state_nxt_s = S_JUMP;
                    default:        state_nxt_s = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (bus.opcode == OP_SW) state_nxt_s = S_MEM_WR;
                else                     state_nxt_s = S_MEM_RD;
            end
            S_MEM_RD: begin
                if (bus.mem_ready) state_nxt_s = S_MEM_WB;
                else               state_nxt_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_nxt_s = S_FETCH;
                else               state_nxt_s = S_MEM_WR;
            end
            S_R_EXEC:   state_nxt_s = S_R_WB;
            S_ORI_EXEC: state_nxt_s = S_ORI_WB;
            default:    state_nxt_s = S_FETCH;
        endcase
    end

    // State register; controls are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            ctrl_r  <= ctrl_decode(S_FETCH);
        end else begin
            state_r <= state_nxt_s;
            ctrl_r  <= ctrl_decode(state_nxt_s);
        end
    end

    // Gating rst_n here keeps PC/IR loads off while reset is held, whatever mem_ready does.
    assign mem_ready_s   = bus.mem_ready & rst_n;
    assign fetch_go_s    = ctrl_r.in_fetch & mem_ready_s;
    assign branch_take_s = ctrl_r.in_branch & ((bus.opcode == OP_BNE) ? ~bus.zero : bus.zero);
    assign illegal_s     = ctrl_r.in_decode & ~op_legal(bus.opcode);

    assign bus.pc_en      = fetch_go_s | ctrl_r.pc_en_u | branch_take_s;
    assign bus.ir_write   = fetch_go_s;
    assign bus.iord       = ctrl_r.iord;
    assign bus.mem_read   = ctrl_r.mem_read;
    assign bus.mem_write  = ctrl_r.mem_write;
    assign bus.reg_dst    = ctrl_r.reg_dst;
    assign bus.mem_to_reg = ctrl_r.mem_to_reg;
    assign bus.reg_write  = ctrl_r.reg_write;
    assign bus.alu_src_a  = ctrl_r.alu_src_a;
    assign bus.alu_src_b  = ctrl_r.alu_src_b;
    assign bus.zero_ext   = ctrl_r.zero_ext;
    assign bus.alu_op     = ctrl_r.alu_op;
    assign bus.pc_source  = ctrl_r.pc_source;
    assign bus.illegal    = illegal_s;
    assign bus.instr_done = ctrl_r.done_u | illegal_s | (ctrl_r.in_memwr & mem_ready_s);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven bench for the multicycle MIPS sequencer: per-cycle expected
// controls are queued on drive and compared mid-cycle, plus an async-reset sequence.
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
        logic       mem_ready;
        out_t       exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    vec_t vecs[$];
    out_t sb_q[$];

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Expected control words, one per state, transcribed from the state table.
    function automatic out_t e_fetch(input logic rdy);
        out_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy;
        return o;
    endfunction
    function automatic out_t e_decode(input logic ill);
        out_t o = '0;
        o.alu_src_b = 2'b11; o.illegal = ill; o.instr_done = ill;
        return o;
    endfunction
    function automatic out_t e_memaddr();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic out_t e_memrd();
        out_t o = '0;
        o.mem_read = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic out_t e_memwb();
        out_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_memwr(input logic rdy);
        out_t o = '0;
        o.mem_write = 1'b1; o.iord = 1'b1; o.instr_done = rdy;
        return o;
    endfunction
    function automatic out_t e_rexec();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b10;
        return o;
    endfunction
    function automatic out_t e_rwb();
        out_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_oriexec();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.zero_ext = 1'b1; o.alu_op = 2'b11;
        return o;
    endfunction
    function automatic out_t e_oriwb();
        out_t o = '0;
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_branch(input logic pc);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01;
        o.instr_done = 1'b1; o.pc_en = pc;
        return o;
    endfunction
    function automatic out_t e_jump(input logic [1:0] src);
        out_t o = '0;
        o.pc_source = src; o.pc_en = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.pc_en = bus.pc_en; o.iord = bus.iord; o.mem_read = bus.mem_read;
        o.mem_write = bus.mem_write; o.ir_write = bus.ir_write; o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg; o.reg_write = bus.reg_write;
        o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.zero_ext = bus.zero_ext;
        o.alu_op = bus.alu_op; o.pc_source = bus.pc_source;
        o.instr_done = bus.instr_done; o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input out_t e, input string nm);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = rdy;
        v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; bus.opcode = v.opcode; bus.funct = v.funct;
        bus.zero = v.zero; bus.mem_ready = v.mem_ready;
        sb_q.push_back(v.exp);
    endtask

    task automatic check(input string nm);
        out_t got;
        out_t exp;
        got = sample();
        n_vec++;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: got %05h, required a queued expectation", nm, got);
        end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
                n_miss++;
                $display("FAIL %s: got %05h required %05h", nm, got, exp);
            end
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check(v.name);
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0;
        bus.opcode = OP_R; bus.funct = FN_ADD; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        add(1'b0, OP_R,  FN_ADD, 1'b0, 1'b0, e_fetch(1'b0), "reset_rdy0");
        add(1'b0, OP_R,  FN_ADD, 1'b0, 1'b1, e_fetch(1'b0), "reset_rdy1");
        // add: 4 cycles
        add(1'b1, OP_R,  FN_ADD, 1'b0, 1'b1, e_fetch(1'b1), "add_fetch");
        add(1'b1, OP_R,  FN_ADD, 1'b0, 1'b1, e_decode(1'b0), "add_decode");
        add(1'b1, OP_R,  FN_ADD, 1'b1, 1'b0, e_rexec(),      "add_rexec");
        add(1'b1, OP_R,  FN_ADD, 1'b0, 1'b1, e_rwb(),        "add_rwb");
        // lw with 2 fetch waits and 3 read waits: 10 cycles
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0), "lw_fwait1");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0), "lw_fwait2");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1), "lw_fetch");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e_decode(1'b0), "lw_decode");
        add(1'b1, OP_LW, 6'd0, 1'b1, 1'b1, e_memaddr(),   "lw_addr");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e_memrd(),     "lw_rwait1");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e_memrd(),     "lw_rwait2");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, e_memrd(),     "lw_rwait3");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e_memrd(),     "lw_rd");
        add(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e_memwb(),     "lw_wb");
        // sw with one write wait
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1), "sw_fetch");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_decode(1'b0), "sw_decode");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_memaddr(),   "sw_addr");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_memwr(1'b0), "sw_wwait");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e_memwr(1'b1), "sw_wr");
        // branches
        add(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b1, e_fetch(1'b1), "beq1_fetch");
        add(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, e_decode(1'b0), "beq1_decode");
        add(1'b1, OP_BEQ, 6'd0, 1'b1, 1'b0, e_branch(1'b1), "beq_z1");
        add(1'b1, OP_BEQ, 6'd0, 1'b1, 1'b1, e_fetch(1'b1), "beq0_fetch");
        add(1'b1, OP_BEQ, 6'd0, 1'b1, 1'b0, e_decode(1'b0), "beq0_decode");
        add(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b1, e_branch(1'b0), "beq_z0");
        add(1'b1, OP_BNE, 6'd0, 1'b0, 1'b1, e_fetch(1'b1), "bne0_fetch");
        add(1'b1, OP_BNE, 6'd0, 1'b0, 1'b0, e_decode(1'b0), "bne0_decode");
        add(1'b1, OP_BNE, 6'd0, 1'b0, 1'b0, e_branch(1'b1), "bne_z0");
        add(1'b1, OP_BNE, 6'd0, 1'b1, 1'b1, e_fetch(1'b1), "bne1_fetch");
        add(1'b1, OP_BNE, 6'd0, 1'b1, 1'b0, e_decode(1'b0), "bne1_decode");
        add(1'b1, OP_BNE, 6'd0, 1'b1, 1'b0, e_branch(1'b0), "bne_z1");
        // ori, jr, j
        add(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, e_fetch(1'b1), "ori_fetch");
        add(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, e_decode(1'b0), "ori_decode");
        add(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, e_oriexec(),   "ori_exec");
        add(1'b1, OP_ORI, 6'd0, 1'b0, 1'b0, e_oriwb(),     "ori_wb");
        add(1'b1, OP_R,   FN_JR, 1'b0, 1'b1, e_fetch(1'b1), "jr_fetch");
        add(1'b1, OP_R,   FN_JR, 1'b0, 1'b0, e_decode(1'b0), "jr_decode");
        add(1'b1, OP_R,   FN_JR, 1'b0, 1'b0, e_jump(2'b11), "jr_exec");
        add(1'b1, OP_J,   6'd0,  1'b0, 1'b1, e_fetch(1'b1), "j_fetch");
        add(1'b1, OP_J,   6'd0,  1'b0, 1'b1, e_decode(1'b0), "j_decode");
        add(1'b1, OP_J,   6'd0,  1'b0, 1'b1, e_jump(2'b10), "j_exec");
        // illegal opcode returns straight to FETCH
        add(1'b1, OP_BAD, 6'd0, 1'b0, 1'b1, e_fetch(1'b1), "ill_fetch");
        add(1'b1, OP_BAD, 6'd0, 1'b0, 1'b1, e_decode(1'b1), "ill_decode");
        add(1'b1, OP_BAD, 6'd0, 1'b0, 1'b0, e_fetch(1'b0), "ill_back");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Async reset during a stalled store must drop mem_write immediately.
        vecs.delete();
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1),  "rs_fetch");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_decode(1'b0), "rs_decode");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_memaddr(),    "rs_addr");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_memwr(1'b0),  "rs_wwait");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end
        #2;
        v = vecs[3];
        v.rst_n = 1'b0;
        v.exp = e_fetch(1'b0);
        drive(v);
        #1;
        check("rs_async");

        vecs.delete();
        add(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b0),  "rs_hold");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0),  "rs_rel0");
        add(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0),  "rs_rel1");
        add(1'b1, OP_R,  FN_ADD, 1'b0, 1'b1, e_fetch(1'b1), "rs_go");
        add(1'b1, OP_R,  FN_ADD, 1'b0, 1'b0, e_decode(1'b0), "rs_decode2");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
